seg7_scan_display: RTL and testbench

- Downstream display stage of the single-cycle CPU top level.
- Consumes the debug buses: dpdata (selected register value), o_pc and o_ins.
- Drives a 4-digit multiplexed active-low 7-segment display with the 16-bit value chosen by dptype.
- Latches a display snapshot once per scan frame, so digits never tear mid-frame.

---
 rtl/seg7_scan_display.sv | 223 ++++++++++++++++++++++
 tb/tb_seg7_scan_display.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_display.sv
// -----------------------------------------------------------------------------
// seg7_scan_display
//
// Purpose:
//   Display stage that sits after the single-cycle CPU top level. It takes the
//   CPU debug buses and shows one 16-bit slice of them on a 4-digit, multiplexed,
//   active-low 7-segment display. One digit is lit at a time. Each digit stays
//   lit for SCAN_DIV clock cycles.
//
//   A snapshot of the selected source is taken once per scan frame, at the tick
//   that starts digit 0. All four digits of a frame therefore come from the same
//   value, so a slice that changes mid-frame never shows a torn number. The
//   decimal point of the digit whose index equals the latched dptype is lit,
//   which tells the user which source is being displayed.
//
// Parameters:
//   SCAN_DIV  clock cycles each digit is held (>= 1)
//   CNT_W     prescaler width, 2**CNT_W >= SCAN_DIV
//
// Ports:
//   clk      in   1   system clock
//   rst      in   1   asynchronous reset, active low (0 = reset)
//   dptype   in   2   source select: 0 dpdata[15:0], 1 dpdata[31:16],
//                     2 o_pc[15:0], 3 o_ins[15:0]
//   dpdata   in  32   register value from the CPU
//   o_pc     in  32   current program counter
//   o_ins    in  32   current instruction
//   node     out  4   digit enables, active low; bit k enables digit k,
//                     digit 0 is the rightmost (least significant) digit
//   segment  out  8   active-low segments, [7]=dp, [6:0]=g,f,e,d,c,b,a
//
// Optional feature:
//   LEADING_ZERO_BLANK_EN - when defined, digits 3..1 go dark (segments g..a
//   off) while every nibble from that digit upward is zero. Digit 0 always
//   shows a value. The dp still follows the source-select rule on dark digits.
// -----------------------------------------------------------------------------
module seg7_scan_display #(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  dptype,
  input  logic [31:0] dpdata,
  input  logic [31:0] o_pc,
  input  logic [31:0] o_ins,
  output logic [3:0]  node,
  output logic [7:0]  segment
);

  // Prescaler value on which the digit-advance tick fires.
  localparam logic [CNT_W-1:0] TICK_COUNT = CNT_W'(SCAN_DIV - 1);

  // The scanner is idle until its first tick after reset. That first tick
  // loads the snapshot and lights digit 0. After that it keeps running.
  typedef enum logic {
    ScanIdle = 1'b0,
    ScanRun  = 1'b1
  } scanState_e;

  scanState_e       state_q, state_d;
  logic [CNT_W-1:0] prescale_q, prescale_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [1:0]       shadowType_q, shadowType_d;
  logic [3:0]       node_q, node_d;
  logic [7:0]       segment_q, segment_d;

  logic             tick;
  logic [15:0]      liveValue;
  logic [3:0]       digitNibble;
  logic [6:0]       digitSeg;
  logic             blankDigit;
  logic             unusedUpperBits;

  // Only the low halves of the PC and instruction buses are ever shown.
  assign unusedUpperBits = ^{o_pc[31:16], o_ins[31:16]};

  // Active-low gfedcba pattern for one hex nibble.
  function automatic logic [6:0] hexToSeg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Live source selection. This value only reaches the display when a frame
  // boundary (or the first tick after reset) copies it into the shadow.
  always_comb begin
    liveValue = dpdata[15:0];
    case (dptype)
      2'd0:    liveValue = dpdata[15:0];
      2'd1:    liveValue = dpdata[31:16];
      2'd2:    liveValue = o_pc[15:0];
      default: liveValue = o_ins[15:0];
    endcase
  end

  // The prescaler counts 0..SCAN_DIV-1. The tick is asserted while it sits at
  // its last value. When SCAN_DIV is 1 the counter stays at zero and the tick
  // fires every cycle.
  assign tick = (prescale_q == TICK_COUNT);

  always_comb begin
    prescale_d = prescale_q + CNT_W'(1);
    if (tick) begin
      prescale_d = '0;
    end
  end

  // Next state for the scanner. Nothing moves except on a tick. The snapshot
  // reloads on the first tick after reset and whenever digit 3 wraps back to
  // digit 0. The reload uses whatever the inputs hold at that edge.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    shadowType_d = shadowType_q;
    if (tick) begin
      case (state_q)
        ScanIdle: begin
          state_d      = ScanRun;
          idx_d        = 2'd0;
          shadow_d     = liveValue;
          shadowType_d = dptype;
        end
        ScanRun: begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            shadow_d     = liveValue;
            shadowType_d = dptype;
          end
        end
        default: begin
          state_d = ScanIdle;
        end
      endcase
    end
  end

  // Nibble for the digit about to be lit. It is taken from the next-state
  // shadow, so digit 0 of a new frame already shows the freshly loaded value.
  always_comb begin
    digitNibble = shadow_d[3:0];
    case (idx_d)
      2'd0:    digitNibble = shadow_d[3:0];
      2'd1:    digitNibble = shadow_d[7:4];
      2'd2:    digitNibble = shadow_d[11:8];
      default: digitNibble = shadow_d[15:12];
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every digit above it are zero.
  // Digit 0 is never treated as a leading zero, so a zero value shows as "0".
  always_comb begin
    blankDigit = 1'b0;
    case (idx_d)
      2'd1:    blankDigit = (shadow_d[15:4] == 12'h000);
      2'd2:    blankDigit = (shadow_d[15:8] == 8'h00);
      2'd3:    blankDigit = (shadow_d[15:12] == 4'h0);
      default: blankDigit = 1'b0;
    endcase
  end
`else
  assign blankDigit = 1'b0;
`endif

  assign digitSeg = blankDigit ? 7'h7F : hexToSeg(digitNibble);

  // The registered outputs are recomputed only on a tick and held otherwise.
  // The dp is lit on the digit whose index matches the latched source select.
  always_comb begin
    node_d    = node_q;
    segment_d = segment_q;
    if (tick) begin
      node_d    = ~(4'b0001 << idx_d);
      segment_d = {(idx_d != shadowType_d), digitSeg};
    end
  end

  // State register. Reset blanks the display at once and restarts the scan
  // from the idle state with a cleared prescaler.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ScanIdle;
      prescale_q   <= '0;
      idx_q        <= 2'd0;
      shadow_q     <= 16'h0000;
      shadowType_q <= 2'd0;
      node_q       <= 4'hF;
      segment_q    <= 8'hFF;
    end else begin
      state_q      <= state_d;
      prescale_q   <= prescale_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      shadowType_q <= shadowType_d;
      node_q       <= node_d;
      segment_q    <= segment_d;
    end
  end

  assign node    = node_q;
  assign segment = segment_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_display
//
// Self-checking bench for seg7_scan_display with SCAN_DIV=4. A table of
// frames gives the source select, the bus values and the four expected
// segment patterns. Expected (node, segment) pairs are pushed to a scoreboard
// queue when the stimulus is driven. They are popped and compared each time
// the DUT lights the next digit. Hand-written sequences cover reset, tearing,
// a change on the boundary edge and an asynchronous reset mid-scan.
// When LEADING_ZERO_BLANK_EN is defined, the leading-zero expectations change.
// -----------------------------------------------------------------------------
module tb_seg7_scan_display;

  localparam int SCAN_DIV = 4;
  localparam int CNT_W    = 4;

  logic        clk;
  logic        rst;
  logic [1:0]  dptype;
  logic [31:0] dpdata;
  logic [31:0] o_pc;
  logic [31:0] o_ins;
  logic [3:0]  node;
  logic [7:0]  segment;

  typedef struct packed {
    logic [3:0] node;
    logic [7:0] seg;
  } exp_t;

  typedef struct {
    logic [1:0]       dptype;
    logic [31:0]      dpdata;
    logic [31:0]      pc;
    logic [31:0]      ins;
    logic [3:0][7:0]  segs;
  } vec_t;

  exp_t sbQ[$];
  vec_t vecs[8];

  int vectorsApplied = 0;
  int miscompares    = 0;

  seg7_scan_display #(
    .SCAN_DIV(SCAN_DIV),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dptype(dptype),
    .dpdata(dpdata),
    .o_pc(o_pc),
    .o_ins(o_ins),
    .node(node),
    .segment(segment)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stop a run that has stalled.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Digit enable expected for digit k.
  function automatic logic [3:0] nodeFor(input int k);
    case (k)
      0:       return 4'hE;
      1:       return 4'hD;
      2:       return 4'hB;
      default: return 4'h7;
    endcase
  endfunction

  task automatic applyStimulus(input vec_t v);
    dptype = v.dptype;
    dpdata = v.dpdata;
    o_pc   = v.pc;
    o_ins  = v.ins;
  endtask

  task automatic expectDigit(input logic [3:0] n, input logic [7:0] s);
    exp_t e;
    e.node = n;
    e.seg  = s;
    sbQ.push_back(e);
  endtask

  // Advance to just after the next digit-advance edge.
  task automatic waitDigit();
    repeat (SCAN_DIV) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name);
    exp_t e;
    vectorsApplied++;
    if (sbQ.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL %s: scoreboard empty, got node=%h segment=%h", name, node, segment);
      return;
    end
    e = sbQ.pop_front();
    if (node !== e.node || segment !== e.seg) begin
      miscompares++;
      $display("[TB] FAIL %s: got node=%h segment=%h, want node=%h segment=%h",
               name, node, segment, e.node, e.seg);
    end
  endtask

  initial begin
    // Frame table: selected 16-bit value and the patterns for digits 0..3.
    vecs[0] = '{2'd0, 32'hDEAD1234, 32'h11110000, 32'h22220000, {8'hF9, 8'hA4, 8'hB0, 8'h19}};
    vecs[1] = '{2'd1, 32'hBEEF1234, 32'h33330000, 32'h44440000, {8'h83, 8'h86, 8'h06, 8'h8E}};
`ifdef LEADING_ZERO_BLANK_EN
    vecs[2] = '{2'd2, 32'h9999AAAA, 32'h55550040, 32'h66667777, {8'hFF, 8'h7F, 8'h99, 8'hC0}};
`else
    vecs[2] = '{2'd2, 32'h9999AAAA, 32'h55550040, 32'h66667777, {8'hC0, 8'h40, 8'h99, 8'hC0}};
`endif
    vecs[3] = '{2'd3, 32'h0000BBBB, 32'h0000CCCC, 32'h12346978, {8'h02, 8'h90, 8'hF8, 8'h80}};
`ifdef LEADING_ZERO_BLANK_EN
    vecs[4] = '{2'd0, 32'h00000005, 32'hFFFF1111, 32'hEEEE2222, {8'hFF, 8'hFF, 8'hFF, 8'h12}};
`else
    vecs[4] = '{2'd0, 32'h00000005, 32'hFFFF1111, 32'hEEEE2222, {8'hC0, 8'hC0, 8'hC0, 8'h12}};
`endif
    vecs[5] = '{2'd0, 32'hFFFFA0B1, 32'h00000000, 32'h00000000, {8'h88, 8'hC0, 8'h83, 8'h79}};
    vecs[6] = '{2'd1, 32'h12340000, 32'h0000ABCD, 32'h00005555, {8'hF9, 8'hA4, 8'h30, 8'h99}};
    vecs[7] = '{2'd2, 32'h00001111, 32'h0000FEDC, 32'h00002222, {8'h8E, 8'h06, 8'hA1, 8'hC6}};

    // Reset held with random inputs: the display stays blank.
    rst    = 1'b0;
    dptype = 2'($urandom);
    dpdata = $urandom;
    o_pc   = $urandom;
    o_ins  = $urandom;
    repeat (3) @(posedge clk);
    #1;
    expectDigit(4'hF, 8'hFF);
    checkOutput("reset.hold0");
    dpdata = $urandom;
    dptype = 2'($urandom);
    @(posedge clk);
    #1;
    expectDigit(4'hF, 8'hFF);
    checkOutput("reset.hold1");

    // Release with the first table frame in place, then run the table.
    applyStimulus(vecs[0]);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) applyStimulus(vecs[i]);
      for (int k = 0; k < 4; k++) expectDigit(nodeFor(k), vecs[i].segs[k]);
      for (int k = 0; k < 4; k++) begin
        waitDigit();
        checkOutput($sformatf("vec%0d.d%0d", i, k));
      end
    end

    // Anti-tear: a change while digit 1 is lit must not reach digits 2 and 3.
    dptype = 2'd0;
    dpdata = 32'h00001234;
    expectDigit(4'hE, 8'h19);
    expectDigit(4'hD, 8'hB0);
    waitDigit(); checkOutput("tear.d0");
    waitDigit(); checkOutput("tear.d1");
    dpdata = 32'h0000ABCD;
    o_ins  = 32'hFFFFFFFF;
    expectDigit(4'hB, 8'hA4);
    expectDigit(4'h7, 8'hF9);
    waitDigit(); checkOutput("tear.d2");
    waitDigit(); checkOutput("tear.d3");
    expectDigit(4'hE, 8'h21);
    expectDigit(4'hD, 8'hC6);
    expectDigit(4'hB, 8'h83);
    expectDigit(4'h7, 8'h88);
    waitDigit(); checkOutput("tear.next.d0");
    waitDigit(); checkOutput("tear.next.d1");
    waitDigit(); checkOutput("tear.next.d2");
    waitDigit(); checkOutput("tear.next.d3");

    // Input changed in the half-cycle before the boundary edge is displayed.
    // A change just after that edge is not.
    repeat (SCAN_DIV - 1) @(posedge clk);
    @(negedge clk);
    dpdata = 32'h00005678;
    expectDigit(4'hE, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("edge.d0");
    @(negedge clk);
    dpdata = 32'h00009999;
    expectDigit(4'hD, 8'hF8);
    expectDigit(4'hB, 8'h82);
    expectDigit(4'h7, 8'h92);
    waitDigit(); checkOutput("edge.d1");
    waitDigit(); checkOutput("edge.d2");
    waitDigit(); checkOutput("edge.d3");

    // Asynchronous reset while digit 2 is lit blanks before the next edge.
    expectDigit(4'hE, 8'h10);
    expectDigit(4'hD, 8'h90);
    expectDigit(4'hB, 8'h90);
    waitDigit(); checkOutput("areset.d0");
    waitDigit(); checkOutput("areset.d1");
    waitDigit(); checkOutput("areset.d2");
    #2;
    rst = 1'b0;
    #1;
    expectDigit(4'hF, 8'hFF);
    checkOutput("areset.blank");
    dpdata = 32'h00001234;
    @(posedge clk);
    #1;
    expectDigit(4'hF, 8'hFF);
    checkOutput("areset.held");
    @(negedge clk);
    rst = 1'b1;
    repeat (SCAN_DIV - 1) @(posedge clk);
    #1;
    expectDigit(4'hF, 8'hFF);
    checkOutput("areset.notyet");
    @(posedge clk);
    #1;
    expectDigit(4'hE, 8'h19);
    checkOutput("areset.first");
    expectDigit(4'hD, 8'hB0);
    waitDigit(); checkOutput("areset.second");

    if (sbQ.size() != 0) begin
      vectorsApplied++;
      miscompares++;
      $display("[TB] FAIL scoreboard.drain: got %0d leftover entries, want 0", sbQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
